xc_aesmix_mc: RTL and testbench



---
 rtl/xc_aesmix_mc_pkg.sv | 36 +++
 rtl/xc_aesmix_byte.sv | 18 +
 rtl/xc_aesmix_mc.sv | 148 ++++++++++++++
 tb/tb_xc_aesmix_mc.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xc_aesmix_mc_pkg.sv
// Shared definitions for the AES MixColumns engine: FSM states, GF(2^8) constants
// and the column coefficient sets.
package xc_aesmix_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef logic [3:0][7:0] col_t;

  localparam logic [7:0] GF_RED = 8'h1b;

  // Coefficient m multiplies column byte (i+m) mod 4 when producing result byte i.
  localparam col_t ENC_COEF = {8'h01, 8'h01, 8'h03, 8'h02};
  localparam col_t DEC_COEF = {8'h09, 8'h0d, 8'h0b, 8'h0e};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_RED : 8'h00);
  endfunction

  // Every AES coefficient fits in 4 bits, so a 3-deep xtime chain is enough.
  function automatic logic [7:0] gf_mul4(input logic [7:0] a, input logic [3:0] coef);
    logic [7:0] x;
    logic [7:0] acc;
    x   = a;
    acc = 8'h00;
    for (int b = 0; b < 4; b++) begin
      if (coef[b]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

endpackage

// File: rtl/xc_aesmix_byte.sv
// One MixColumns / InvMixColumns output byte from a column pre-rotated so that
// col[0] is the byte at the result position.
module xc_aesmix_byte
  import xc_aesmix_mc_pkg::*;
(
  input  logic [3:0][7:0] col,
  input  logic            enc,
  output logic [7:0]      res_c
);

  always_comb begin
    res_c = 8'h00;
    for (int m = 0; m < 4; m++) begin
      res_c = res_c ^ gf_mul4(col[m], enc ? ENC_COEF[m][3:0] : DEC_COEF[m][3:0]);
    end
  end

endmodule

// File: rtl/xc_aesmix_mc.sv
// Handshaked AES MixColumns / InvMixColumns engine: NCOL columns per transaction,
// BPC result bytes per column per cycle, result held until consumed.
module xc_aesmix_mc
  import xc_aesmix_mc_pkg::*;
#(
  parameter int unsigned NCOL = 1,
  parameter int unsigned BPC  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_enc,
  input  logic [32*NCOL-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [32*NCOL-1:0]   out_data,
  output logic                 busy
);

  localparam int unsigned S      = 4 / BPC;
  localparam int unsigned STEP_W = (S > 1) ? $clog2(S) : 1;

  state_e                          state_q, state_d;
  logic [STEP_W-1:0]               step_q, step_d;
  col_t [NCOL-1:0]                 op_q, op_d;
  col_t [NCOL-1:0]                 out_q, out_d;
  logic                            enc_q, enc_d;
  logic                            valid_q, valid_d;
  logic                            busy_q, busy_d;
  logic [NCOL-1:0][BPC-1:0][7:0]   res_all;
  logic [1:0]                      lane_base;

  assign lane_base = 2'(32'(step_q) * BPC);

  // Byte lanes: lane j of column c produces result byte lane_base+j this step.
  for (genvar c = 0; c < NCOL; c++) begin : g_col
    for (genvar j = 0; j < BPC; j++) begin : g_lane
      logic [1:0]      idx;
      logic [3:0][7:0] rot;
      logic [7:0]      res;

      always_comb begin
        idx = lane_base + 2'(j);
        for (int m = 0; m < 4; m++) begin
          rot[m] = op_q[c][2'(idx + 2'(m))];
        end
      end

      xc_aesmix_byte u_byte (
        .col   (rot),
        .enc   (enc_q),
        .res_c (res)
      );

      assign res_all[c][j] = res;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    op_d     = op_q;
    enc_d    = enc_q;
    valid_d  = valid_q;
    out_d    = out_q;
    in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);

    if (flush) begin
      state_d = ST_IDLE;
      step_d  = '0;
      valid_d = 1'b0;
      op_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_d = ST_RUN;
            step_d  = '0;
            op_d    = in_data;
            enc_d   = in_enc;
          end
        end
        ST_RUN: begin
          for (int c = 0; c < int'(NCOL); c++) begin
            for (int j = 0; j < int'(BPC); j++) begin
              out_d[c][lane_base + 2'(j)] = res_all[c][j];
            end
          end
          if (step_q == STEP_W'(S - 1)) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            valid_d = 1'b0;
            op_d    = '0;
            if (in_valid) begin
              state_d = ST_RUN;
              step_d  = '0;
              op_d    = in_data;
              enc_d   = in_enc;
            end else begin
              state_d = ST_IDLE;
              step_d  = '0;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          step_d  = '0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      op_q    <= '0;
      enc_q   <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      op_q    <= op_d;
      enc_q   <= enc_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_xc_aesmix_mc.sv
// Bench for xc_aesmix_mc: four configurations side by side, checked against a
// plain GF(2^8) MixColumns model.
module tb_xc_aesmix_mc;

  function automatic int unsigned nc_of(input int g);
    case (g)
      0: return 1;
      1: return 1;
      2: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int unsigned bpc_of(input int g);
    case (g)
      0: return 1;
      1: return 4;
      2: return 2;
      default: return 2;
    endcase
  endfunction

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   flush, in_valid, in_enc, out_ready;
  logic [127:0] in_data [4];
  logic [3:0]   in_ready, out_valid, busy, op_nz;
  logic [127:0] out_data [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned NC = nc_of(g);
    localparam int unsigned BP = bpc_of(g);
    logic [32*NC-1:0] od;

    xc_aesmix_mc #(.NCOL(NC), .BPC(BP)) u_dut (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_enc    (in_enc[g]),
      .in_data   (in_data[g][32*NC-1:0]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (od),
      .busy      (busy[g])
    );

    assign out_data[g] = 128'(od);
    assign op_nz[g]    = |u_dut.op_q;
  end

  // Reference: shift-and-add GF(2^8) multiply, reduction polynomial 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_ref(input int nc, input logic [127:0] d, input logic enc);
    logic [7:0]   coef [4];
    logic [127:0] r;
    logic [7:0]   acc;
    if (enc) begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end else begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end
    r = '0;
    for (int c = 0; c < nc; c++) begin
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[k], d[32*c + 8*((i + k) % 4) +: 8]);
        r[32*c + 8*i +: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Offer one transaction and wait (bounded) for out_valid; lat counts edges after accept.
  task automatic run_txn(input int g, input logic [127:0] d, input logic enc,
                         output int lat, output logic [127:0] res);
    @(negedge clock);
    in_valid[g] = 1'b1;
    in_data[g]  = d;
    in_enc[g]   = enc;
    @(posedge clock); #1;
    in_valid[g] = 1'b0;
    in_data[g]  = rand128();
    in_enc[g]   = ~enc;
    lat = 0;
    while (!out_valid[g] && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    res = out_data[g];
  endtask

  task automatic consume(input int g);
    @(negedge clock);
    out_ready[g] = 1'b1;
    @(posedge clock); #1;
    out_ready[g] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    flush = '0; in_valid = '0; in_enc = '0; out_ready = '0;
    for (int g = 0; g < 4; g++) in_data[g] = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    for (int g = 0; g < 4; g++) begin
      n_checks += 4;
      if (in_ready[g] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready g=%0d got=%b exp=1", g, in_ready[g]); end
      if (out_valid[g] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid g=%0d got=%b exp=0", g, out_valid[g]); end
      if (busy[g] !== 1'b0) begin n_fail++; $display("FAIL reset_busy g=%0d got=%b exp=0", g, busy[g]); end
      if (out_data[g] !== 128'h0) begin n_fail++; $display("FAIL reset_out_data g=%0d got=%h exp=0", g, out_data[g]); end
    end
  endtask

  task automatic test_known_vectors();
    int lat;
    logic [127:0] res;
    out_ready[0] = 1'b1;
    run_txn(0, 128'h455313db, 1'b1, lat, res);
    n_checks += 2;
    if (lat !== 4) begin n_fail++; $display("FAIL kv0_latency got=%0d exp=4", lat); end
    if (res !== 128'hbca14d8e) begin n_fail++; $display("FAIL kv0_data got=%h exp=bca14d8e", res); end
    @(posedge clock); #1;
    out_ready[0] = 1'b0;
    n_checks += 3;
    if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL kv0_drain_valid got=%b exp=0", out_valid[0]); end
    if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL kv0_drain_busy got=%b exp=0", busy[0]); end
    if (op_nz[0] !== 1'b0) begin n_fail++; $display("FAIL kv0_operand_scrub got=%b exp=0", op_nz[0]); end

    run_txn(1, 128'hbca14d8e, 1'b0, lat, res);
    n_checks += 2;
    if (lat !== 1) begin n_fail++; $display("FAIL kv1_latency got=%0d exp=1", lat); end
    if (res !== 128'h455313db) begin n_fail++; $display("FAIL kv1_inv_data got=%h exp=455313db", res); end
    consume(1);
    run_txn(1, 128'h5c220af2, 1'b1, lat, res);
    n_checks += 1;
    if (res !== 128'h9d58dc9f) begin n_fail++; $display("FAIL kv1_enc_data got=%h exp=9d58dc9f", res); end
    consume(1);

    run_txn(2, {64'h0, 32'hd5d4d4d4, 32'hc6c6c6c6}, 1'b1, lat, res);
    n_checks += 2;
    if (lat !== 2) begin n_fail++; $display("FAIL kv2_latency got=%0d exp=2", lat); end
    if (res !== {64'h0, 32'hd6d7d5d5, 32'hc6c6c6c6}) begin
      n_fail++; $display("FAIL kv2_data got=%h exp=%h", res, {64'h0, 32'hd6d7d5d5, 32'hc6c6c6c6});
    end
    consume(2);
    n_checks += 1;
    if (busy[2] !== 1'b0) begin n_fail++; $display("FAIL kv2_idle_busy got=%b exp=0", busy[2]); end
  endtask

  task automatic test_random();
    int lat;
    logic [127:0] res, d, exp;
    logic enc;
    for (int g = 0; g < 4; g++) begin
      for (int t = 0; t < 6; t++) begin
        d   = rand128();
        enc = 1'($urandom_range(0, 1));
        exp = mix_ref(int'(nc_of(g)), d, enc);
        run_txn(g, d, enc, lat, res);
        n_checks += 2;
        if (lat !== int'(4 / bpc_of(g))) begin
          n_fail++; $display("FAIL rand_latency g=%0d t=%0d got=%0d exp=%0d", g, t, lat, 4 / bpc_of(g));
        end
        if (res !== exp) begin
          n_fail++; $display("FAIL rand_data g=%0d t=%0d enc=%b got=%h exp=%h", g, t, enc, res, exp);
        end
        consume(g);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [127:0] res, d, exp;
    logic enc;
    d   = rand128();
    enc = 1'($urandom_range(0, 1));
    exp = mix_ref(4, d, enc);
    run_txn(3, d, enc, lat, res);
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      n_checks += 3;
      if (out_data[3] !== exp) begin n_fail++; $display("FAIL bp_hold_data k=%0d got=%h exp=%h", k, out_data[3], exp); end
      if (in_ready[3] !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready k=%0d got=%b exp=0", k, in_ready[3]); end
      if (out_valid[3] !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid k=%0d got=%b exp=1", k, out_valid[3]); end
    end
    @(negedge clock);
    out_ready[3] = 1'b1;
    in_valid[3]  = 1'b1;
    in_data[3]   = {4{32'h01010101}};
    in_enc[3]    = 1'($urandom_range(0, 1));
    #1;
    n_checks += 1;
    if (in_ready[3] !== 1'b1) begin n_fail++; $display("FAIL b2b_comb_ready got=%b exp=1", in_ready[3]); end
    @(posedge clock); #1;
    out_ready[3] = 1'b0;
    in_valid[3]  = 1'b0;
    in_data[3]   = rand128();
    n_checks += 2;
    if (out_valid[3] !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_drop got=%b exp=0", out_valid[3]); end
    if (busy[3] !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got=%b exp=1", busy[3]); end
    lat = 0;
    while (!out_valid[3] && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    n_checks += 2;
    if (lat !== 2) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=2", lat); end
    if (out_data[3] !== {4{32'h01010101}}) begin
      n_fail++; $display("FAIL b2b_data got=%h exp=%h", out_data[3], {4{32'h01010101}});
    end
    consume(3);
  endtask

  task automatic test_flush();
    int lat;
    logic [127:0] res;
    @(negedge clock);
    in_valid[0] = 1'b1;
    in_data[0]  = rand128();
    in_enc[0]   = 1'b1;
    @(posedge clock); #1;
    in_valid[0] = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    flush[0] = 1'b1;
    @(posedge clock); #1;
    flush[0] = 1'b0;
    n_checks += 4;
    if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", out_valid[0]); end
    if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b exp=0", busy[0]); end
    if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=1", in_ready[0]); end
    if (op_nz[0] !== 1'b0) begin n_fail++; $display("FAIL flush_operand_scrub got=%b exp=0", op_nz[0]); end
    run_txn(0, 128'h455313db, 1'b1, lat, res);
    n_checks += 2;
    if (lat !== 4) begin n_fail++; $display("FAIL post_flush_latency got=%0d exp=4", lat); end
    if (res !== 128'hbca14d8e) begin n_fail++; $display("FAIL post_flush_data got=%h exp=bca14d8e", res); end
    consume(0);

    @(negedge clock);
    flush[1]    = 1'b1;
    in_valid[1] = 1'b1;
    in_data[1]  = rand128();
    @(posedge clock); #1;
    flush[1]    = 1'b0;
    in_valid[1] = 1'b0;
    n_checks += 1;
    if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL flush_blocks_accept got=%b exp=0", busy[1]); end
  endtask

  task automatic test_async_reset();
    int lat;
    logic [127:0] res, d, exp;
    @(negedge clock);
    in_valid[0] = 1'b1;
    in_data[0]  = rand128();
    in_enc[0]   = 1'b0;
    @(posedge clock); #1;
    in_valid[0] = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    for (int g = 0; g < 4; g++) begin
      n_checks += 3;
      if (out_valid[g] !== 1'b0) begin n_fail++; $display("FAIL areset_valid g=%0d got=%b exp=0", g, out_valid[g]); end
      if (out_data[g] !== 128'h0) begin n_fail++; $display("FAIL areset_data g=%0d got=%h exp=0", g, out_data[g]); end
      if (busy[g] !== 1'b0) begin n_fail++; $display("FAIL areset_busy g=%0d got=%b exp=0", g, busy[g]); end
    end
    n_checks += 1;
    if (op_nz[0] !== 1'b0) begin n_fail++; $display("FAIL areset_operand got=%b exp=0", op_nz[0]); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_checks += 1;
    if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL areset_release_ready got=%b exp=1", in_ready[0]); end
    d   = rand128();
    exp = mix_ref(1, d, 1'b1);
    run_txn(0, d, 1'b1, lat, res);
    n_checks += 2;
    if (lat !== 4) begin n_fail++; $display("FAIL areset_after_latency got=%0d exp=4", lat); end
    if (res !== exp) begin n_fail++; $display("FAIL areset_after_data got=%h exp=%h", res, exp); end
    consume(0);
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_random();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
